// File: rtl/loopboard_pkg.sv
// Shared widths and FSM state encoding for the looper SDRAM master.
package loopboard_pkg;
    localparam int ADDR_W = 25;
    localparam int DATA_W = 32;
    localparam int CH_W   = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        ADVANCE
    } state_e;
endpackage

// File: rtl/loop_sdram_master_sat_add16.sv
// 16-bit signed adder that clamps to the signed range instead of wrapping.
module sat_add16
    import loopboard_pkg::*;
(
    input  logic [CH_W-1:0] a_i,
    input  logic [CH_W-1:0] b_i,
    output logic [CH_W-1:0] sum_o
);
    logic [CH_W-1:0] raw;

    assign raw = a_i + b_i;

    // Overflow only when both operands share a sign the result does not.
    always_comb begin
        sum_o = raw;
        if ((a_i[CH_W-1] == b_i[CH_W-1]) && (raw[CH_W-1] != a_i[CH_W-1]))
            sum_o = a_i[CH_W-1] ? {1'b1, {(CH_W-1){1'b0}}} : {1'b0, {(CH_W-1){1'b1}}};
    end
endmodule

// File: rtl/loop_sdram_master.sv
// Looper SDRAM master: records, overdubs and plays back one audio frame per
// strobe through a single-outstanding Avalon-MM transfer sequence.
module loop_sdram_master
    import loopboard_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 25'h0000000,
    parameter logic [ADDR_W-1:0] MAX_WORDS = 25'h1000000
) (
    input  logic              clk_clk,
    input  logic              reset_n_reset_n,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_in_valid,
    input  logic              rec_en,
    input  logic              play_en,
    input  logic              clear,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_out_valid,
    output logic [ADDR_W-1:0] loop_len,
    output logic              frame_overrun,
    output logic [ADDR_W-1:0] sdram_address,
    output logic [3:0]        sdram_byteenable_n,
    output logic              sdram_chipselect,
    output logic [DATA_W-1:0] sdram_writedata,
    output logic              sdram_read_n,
    output logic              sdram_write_n,
    input  logic [DATA_W-1:0] sdram_readdata,
    input  logic              sdram_readdatavalid,
    input  logic              sdram_waitrequest
);
    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q, loop_len_q;
    logic [DATA_W-1:0] smp_q, rd_q, out_q, wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_n_q;
    logic              rec_q, clr_pend_q, out_vld_q, ovr_q, cs_q, rd_n_q, wr_n_q;

    logic [ADDR_W-1:0] len_d, ptr_d;
    logic [DATA_W-1:0] mix_d;

    sat_add16 u_sat_l (
        .a_i   (sdram_readdata[31:16]),
        .b_i   (smp_q[31:16]),
        .sum_o (mix_d[31:16])
    );

    sat_add16 u_sat_r (
        .a_i   (sdram_readdata[15:0]),
        .b_i   (smp_q[15:0]),
        .sum_o (mix_d[15:0])
    );

    // Loop length / pointer as seen by a frame accepted this IDLE cycle,
    // after any clear and any first-pass commit have been folded in.
    always_comb begin
        len_d = loop_len_q;
        ptr_d = ptr_q;
        if (clear || clr_pend_q) begin
            len_d = '0;
            ptr_d = '0;
        end
        if (!rec_en && (len_d == '0) && (ptr_d != '0)) begin
            len_d = ptr_d;
            ptr_d = '0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_n_reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            loop_len_q <= '0;
            smp_q      <= '0;
            rd_q       <= '0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            ovr_q      <= 1'b0;
            rec_q      <= 1'b0;
            clr_pend_q <= 1'b0;
            cs_q       <= 1'b0;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_n_q     <= 4'hF;
        end else begin
            out_vld_q <= 1'b0;
            ovr_q     <= sample_in_valid && (state_q != IDLE);
            if (clear && (state_q != IDLE))
                clr_pend_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    loop_len_q <= len_d;
                    ptr_q      <= ptr_d;
                    clr_pend_q <= 1'b0;
                    if (sample_in_valid) begin
                        smp_q <= sample_in;
                        rec_q <= rec_en;
                        rd_q  <= '0;
                        if ((len_d != '0) && (play_en || rec_en)) begin
                            state_q <= RD_REQ;
                            cs_q    <= 1'b1;
                            rd_n_q  <= 1'b0;
                            be_n_q  <= 4'h0;
                            addr_q  <= BASE_ADDR + ptr_d;
                        end else if (rec_en) begin
                            state_q <= WR_REQ;
                            cs_q    <= 1'b1;
                            wr_n_q  <= 1'b0;
                            be_n_q  <= 4'h0;
                            addr_q  <= BASE_ADDR + ptr_d;
                            wdata_q <= sample_in;
                        end else begin
                            state_q <= ADVANCE;
                        end
                    end
                end
                RD_REQ: begin
                    if (!sdram_waitrequest) begin
                        cs_q    <= 1'b0;
                        rd_n_q  <= 1'b1;
                        be_n_q  <= 4'hF;
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (sdram_readdatavalid) begin
                        rd_q <= sdram_readdata;
                        if (rec_q) begin
                            // Overdub lands on the word just read; address is unchanged.
                            state_q <= WR_REQ;
                            cs_q    <= 1'b1;
                            wr_n_q  <= 1'b0;
                            be_n_q  <= 4'h0;
                            wdata_q <= mix_d;
                        end else begin
                            state_q <= ADVANCE;
                        end
                    end
                end
                WR_REQ: begin
                    if (!sdram_waitrequest) begin
                        cs_q    <= 1'b0;
                        wr_n_q  <= 1'b1;
                        be_n_q  <= 4'hF;
                        state_q <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    out_vld_q <= 1'b1;
                    out_q     <= (play_en && (loop_len_q != '0)) ? rd_q : '0;
                    state_q   <= IDLE;
                    if (loop_len_q == '0) begin
                        if (rec_q) begin
                            if (ptr_q == MAX_WORDS - 25'd1) begin
                                loop_len_q <= MAX_WORDS;
                                ptr_q      <= '0;
                            end else begin
                                ptr_q <= ptr_q + 25'd1;
                            end
                        end
                    end else if (ptr_q == loop_len_q - 25'd1) begin
                        ptr_q <= '0;
                    end else begin
                        ptr_q <= ptr_q + 25'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sample_out         = out_q;
    assign sample_out_valid   = out_vld_q;
    assign loop_len           = loop_len_q;
    assign frame_overrun      = ovr_q;
    assign sdram_address      = addr_q;
    assign sdram_byteenable_n = be_n_q;
    assign sdram_chipselect   = cs_q;
    assign sdram_writedata    = wdata_q;
    assign sdram_read_n       = rd_n_q;
    assign sdram_write_n      = wr_n_q;
endmodule

// File: tb/tb_loop_sdram_master.sv
// Scoreboard bench: expected Avalon commands and playback frames are queued
// by the stimulus; negedge monitors pop and compare as the DUT produces them.
module tb_loop_sdram_master;
    localparam logic [24:0] BASE = 25'd16;
    localparam logic [24:0] MAXW = 25'd6;

    logic        clk_clk = 1'b0;
    logic        reset_n_reset_n = 1'b0;
    logic [31:0] sample_in = '0;
    logic        sample_in_valid = 1'b0;
    logic        rec_en = 1'b0, play_en = 1'b0, clear = 1'b0;
    logic [31:0] sample_out;
    logic        sample_out_valid;
    logic [24:0] loop_len;
    logic        frame_overrun;
    logic [24:0] sdram_address;
    logic [3:0]  sdram_byteenable_n;
    logic        sdram_chipselect;
    logic [31:0] sdram_writedata;
    logic        sdram_read_n, sdram_write_n;
    logic [31:0] sdram_readdata = '0;
    logic        sdram_readdatavalid = 1'b0;
    logic        sdram_waitrequest = 1'b0;

    loop_sdram_master #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk_clk(clk_clk), .reset_n_reset_n(reset_n_reset_n),
        .sample_in(sample_in), .sample_in_valid(sample_in_valid),
        .rec_en(rec_en), .play_en(play_en), .clear(clear),
        .sample_out(sample_out), .sample_out_valid(sample_out_valid),
        .loop_len(loop_len), .frame_overrun(frame_overrun),
        .sdram_address(sdram_address), .sdram_byteenable_n(sdram_byteenable_n),
        .sdram_chipselect(sdram_chipselect), .sdram_writedata(sdram_writedata),
        .sdram_read_n(sdram_read_n), .sdram_write_n(sdram_write_n),
        .sdram_readdata(sdram_readdata), .sdram_readdatavalid(sdram_readdatavalid),
        .sdram_waitrequest(sdram_waitrequest)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        bit          wr;
        logic [24:0] addr;
        logic [31:0] data;
    } cmd_t;

    cmd_t        exp_cmd[$];
    logic [31:0] exp_out[$];
    logic [31:0] mem [0:63];
    int          total = 0, bad = 0;
    int          ovr_cnt = 0, exp_ovr = 0;
    int          rd_cnt = 0;
    logic [31:0] rd_hold = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic exp_rd(input logic [24:0] a);
        cmd_t c;
        c.wr = 1'b0; c.addr = a; c.data = '0;
        exp_cmd.push_back(c);
    endtask

    task automatic exp_wr(input logic [24:0] a, input logic [31:0] d);
        cmd_t c;
        c.wr = 1'b1; c.addr = a; c.data = d;
        exp_cmd.push_back(c);
    endtask

    // SDRAM slave model plus command scoreboard.
    always @(negedge clk_clk) begin
        cmd_t c;
        sdram_readdatavalid = 1'b0;
        if (rd_cnt == 1) begin
            sdram_readdatavalid = 1'b1;
            sdram_readdata      = rd_hold;
        end
        if (rd_cnt > 0) rd_cnt--;
        if (reset_n_reset_n && sdram_chipselect === 1'b1 && !sdram_waitrequest) begin
            if (exp_cmd.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_cmd: got addr %h wr_n %b want none", sdram_address, sdram_write_n);
            end else begin
                c = exp_cmd.pop_front();
                chk("cmd_is_write", {31'd0, ~sdram_write_n}, {31'd0, c.wr});
                chk("cmd_addr", {7'd0, sdram_address}, {7'd0, c.addr});
                chk("cmd_be_n", {28'd0, sdram_byteenable_n}, 32'd0);
                if (c.wr) chk("cmd_wdata", sdram_writedata, c.data);
            end
            if (!sdram_write_n) mem[sdram_address[5:0]] = sdram_writedata;
            else begin
                rd_hold = mem[sdram_address[5:0]];
                rd_cnt  = 1;
            end
        end
    end

    always @(negedge clk_clk) begin
        logic [31:0] e;
        if (reset_n_reset_n && sample_out_valid === 1'b1) begin
            if (exp_out.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_out: got %h want none", sample_out);
            end else begin
                e = exp_out.pop_front();
                chk("sample_out", sample_out, e);
            end
        end
        if (reset_n_reset_n && frame_overrun === 1'b1) ovr_cnt++;
    end

    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_clk);
            if (sample_out_valid === 1'b1) begin
                lat = i + 1;
                break;
            end
        end
        if (lat < 0) chk("out_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse(input logic [31:0] d);
        @(posedge clk_clk); #1;
        sample_in = d; sample_in_valid = 1'b1;
        @(posedge clk_clk); #1;
        sample_in_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, output int lat);
        pulse(d);
        wait_out(lat);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    initial begin
        int lat;
        bit stable;
        logic [31:0] fp [0:5];
        for (int i = 0; i < 64; i++) mem[i] = '0;

        // Reset state
        idle(3);
        @(negedge clk_clk);
        chk("rst_loop_len", {7'd0, loop_len}, 32'd0);
        chk("rst_cs", {31'd0, sdram_chipselect}, 32'd0);
        chk("rst_read_n", {31'd0, sdram_read_n}, 32'd1);
        chk("rst_write_n", {31'd0, sdram_write_n}, 32'd1);
        chk("rst_be_n", {28'd0, sdram_byteenable_n}, 32'hF);
        chk("rst_addr", {7'd0, sdram_address}, 32'd0);
        chk("rst_wdata", sdram_writedata, 32'd0);
        chk("rst_out", sample_out, 32'd0);
        chk("rst_out_valid", {31'd0, sample_out_valid}, 32'd0);
        chk("rst_overrun", {31'd0, frame_overrun}, 32'd0);
        @(posedge clk_clk); #1;
        reset_n_reset_n = 1'b1;

        // First pass of four frames, then rec off commits the loop
        rec_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            logic [31:0] d;
            d = {16'(i), 16'(2 * i)};
            exp_wr(BASE + 25'(i - 1), d);
            exp_out.push_back(32'h0);
            send(d, lat);
            if (i == 1) chk("write_only_latency", 32'(lat), 32'd3);
        end
        rec_en = 1'b0;
        idle(2);
        @(negedge clk_clk);
        chk("first_pass_len", {7'd0, loop_len}, 32'd4);

        // Overdub: saturating and non-saturating mixes
        mem[16] = 32'h7000_8100;
        rec_en = 1'b1; play_en = 1'b1;
        exp_rd(BASE); exp_wr(BASE, 32'h7FFF_8000); exp_out.push_back(32'h7000_8100);
        send(32'h2000_F000, lat);
        exp_rd(BASE + 1); exp_wr(BASE + 1, 32'h0003_0003); exp_out.push_back(32'h0002_0004);
        send(32'h0001_FFFF, lat);
        rec_en = 1'b0; play_en = 1'b0;

        // Clear while idle
        @(posedge clk_clk); #1; clear = 1'b1;
        @(posedge clk_clk); #1; clear = 1'b0;
        @(negedge clk_clk);
        chk("clear_idle_len", {7'd0, loop_len}, 32'd0);

        // Three-word loop, then seven playback frames wrapping twice
        rec_en = 1'b1;
        fp[0] = 32'h1111_2222; fp[1] = 32'h3333_4444; fp[2] = 32'h5555_6666;
        for (int i = 0; i < 3; i++) begin
            exp_wr(BASE + 25'(i), fp[i]); exp_out.push_back(32'h0);
            send(fp[i], lat);
        end
        rec_en = 1'b0;
        idle(2);
        @(negedge clk_clk);
        chk("loop3_len", {7'd0, loop_len}, 32'd3);
        play_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            exp_rd(BASE + 25'(i % 3)); exp_out.push_back(fp[i % 3]);
            send(32'hDEAD_0000 + 32'(i), lat);
        end

        // Stalled read with a frame arriving mid-transfer (ptr is 1 here)
        exp_rd(BASE + 1); exp_out.push_back(fp[1]); exp_ovr = 1;
        @(posedge clk_clk); #1;
        sdram_waitrequest = 1'b1; sample_in = 32'hAAAA_AAAA; sample_in_valid = 1'b1;
        @(posedge clk_clk); #1;
        sample_in_valid = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_clk); #1;
            sample_in = 32'hBBBB_BBBB; sample_in_valid = (i == 2);
            @(negedge clk_clk);
            if (sdram_chipselect !== 1'b1 || sdram_read_n !== 1'b0 || sdram_address !== BASE + 1)
                stable = 1'b0;
        end
        chk("stall_cmd_stable", {31'd0, stable}, 32'd1);
        @(posedge clk_clk); #1;
        sdram_waitrequest = 1'b0;
        wait_out(lat);
        exp_rd(BASE + 2); exp_out.push_back(fp[2]);
        send(32'h0, lat);
        chk("overrun_pulses", 32'(ovr_cnt), 32'(exp_ovr));

        // Clear during RD_WAIT: read completes, frame emitted, then loop discarded
        exp_rd(BASE); exp_out.push_back(fp[0]);
        pulse(32'h0);
        @(posedge clk_clk); #1; clear = 1'b1;
        @(posedge clk_clk); #1; clear = 1'b0;
        wait_out(lat);
        @(negedge clk_clk);
        chk("clear_rdwait_len", {7'd0, loop_len}, 32'd0);
        rec_en = 1'b1;
        exp_wr(BASE, 32'h0A0A_0B0B); exp_out.push_back(32'h0);
        send(32'h0A0A_0B0B, lat);

        // Reset while a write is stalled
        @(posedge clk_clk); #1;
        sdram_waitrequest = 1'b1; sample_in = 32'h1234_5678; sample_in_valid = 1'b1;
        @(posedge clk_clk); #1;
        sample_in_valid = 1'b0;
        @(posedge clk_clk); #1;
        reset_n_reset_n = 1'b0;
        @(posedge clk_clk); #1;
        @(negedge clk_clk);
        chk("mid_rst_write_n", {31'd0, sdram_write_n}, 32'd1);
        chk("mid_rst_cs", {31'd0, sdram_chipselect}, 32'd0);
        chk("mid_rst_len", {7'd0, loop_len}, 32'd0);
        @(posedge clk_clk); #1;
        reset_n_reset_n = 1'b1; sdram_waitrequest = 1'b0; rec_en = 1'b0; play_en = 1'b0;

        // No loop, no record: frame passes through as silence, ptr stays put
        exp_out.push_back(32'h0);
        send(32'h7777_7777, lat);

        // Fill to MAX_WORDS: loop commits automatically and ptr wraps
        rec_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fp[i] = 32'h0100_0000 + 32'(i);
            exp_wr(BASE + 25'(i), fp[i]); exp_out.push_back(32'h0);
            send(fp[i], lat);
        end
        @(negedge clk_clk);
        chk("max_words_len", {7'd0, loop_len}, 32'(MAXW));
        rec_en = 1'b0; play_en = 1'b1;
        exp_rd(BASE); exp_out.push_back(fp[0]);
        send(32'h0, lat);

        idle(4);
        chk("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
        chk("out_queue_empty", 32'(exp_out.size()), 32'd0);
        chk("overrun_total", 32'(ovr_cnt), 32'(exp_ovr));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end
endmodule
